// File: rtl/lock_pkg.sv
// Shared types and constants for the code-lock keypad front end.
package lock_pkg;
  localparam int CODE_W  = 16;
  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    OPEN,
    FAIL,
    LOCKOUT
  } state_t;
endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that parks at zero; times both the open and lockout windows.
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/lock_keypad_entry.sv
// Keypad entry controller: assembles a 4-digit code, requests a compare, and
// drives unlock / fail / alarm with a consecutive-wrong-attempt lockout.
module lock_keypad_entry
  import lock_pkg::*;
#(
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 key_valid,
  input  logic [DIGIT_W-1:0]   key_digit,
  input  logic                 key_enter,
  input  logic                 key_cancel,
  input  logic                 equal,
  output logic [CODE_W-1:0]    pressed_code,
  output logic [2:0]           digit_count,
  output logic                 check,
  output logic                 unlock,
  output logic                 fail,
  output logic                 alarm
);
  localparam int MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  state_t              state, state_n;
  logic [CODE_W-1:0]   code_n;
  logic [2:0]          count_n;
  logic [3:0]          tries, tries_n;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_value;
  logic                tmr_zero;
  logic                wrong;

  lock_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .clr        (clr),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      pressed_code <= '0;
      digit_count  <= '0;
      tries        <= '0;
    end else begin
      state        <= state_n;
      pressed_code <= code_n;
      digit_count  <= count_n;
      tries        <= tries_n;
    end
  end

  always_comb begin
    state_n   = state;
    code_n    = pressed_code;
    count_n   = digit_count;
    tries_n   = tries;
    tmr_load  = 1'b0;
    tmr_value = '0;
    wrong     = 1'b0;

    case (state)
      IDLE: begin
        // Cancel and enter outrank a digit even though both are no-ops here.
        if (!key_cancel && !key_enter && key_valid) begin
          code_n  = {pressed_code[CODE_W-DIGIT_W-1:0], key_digit};
          count_n = (digit_count == 3'(DIGITS)) ? digit_count : digit_count + 3'd1;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (key_cancel) begin
          code_n  = '0;
          count_n = '0;
          state_n = IDLE;
        end else if (key_enter) begin
          if (digit_count == 3'(DIGITS))
            state_n = CHECK;
          else
            wrong = 1'b1;
        end else if (key_valid) begin
          code_n  = {pressed_code[CODE_W-DIGIT_W-1:0], key_digit};
          count_n = (digit_count == 3'(DIGITS)) ? digit_count : digit_count + 3'd1;
        end
      end
      CHECK: begin
        if (equal) begin
          state_n   = OPEN;
          tries_n   = '0;
          tmr_load  = 1'b1;
          tmr_value = OPEN_LOAD;
        end else begin
          wrong = 1'b1;
        end
      end
      OPEN: begin
        if (tmr_zero) begin
          state_n = IDLE;
          code_n  = '0;
          count_n = '0;
        end
      end
      FAIL: begin
        state_n = IDLE;
        code_n  = '0;
        count_n = '0;
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_n = IDLE;
          code_n  = '0;
          count_n = '0;
          tries_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Short entries and comparator misses share one wrong-attempt path.
    if (wrong) begin
      if (int'(tries) + 1 == MAX_TRIES) begin
        state_n   = LOCKOUT;
        tmr_load  = 1'b1;
        tmr_value = LOCK_LOAD;
      end else begin
        state_n = FAIL;
        tries_n = tries + 4'd1;
      end
    end
  end

  assign check  = (state == CHECK);
  assign unlock = (state == OPEN);
  assign fail   = (state == FAIL);
  assign alarm  = (state == LOCKOUT);
endmodule

// File: tb/tb_lock_keypad_entry.sv
// Directed bench for lock_keypad_entry with a fixed lock code of 0x1234.
module tb_lock_keypad_entry;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'h0;
  logic        key_enter = 1'b0;
  logic        key_cancel = 1'b0;
  logic        equal;
  logic [15:0] pressed_code;
  logic [2:0]  digit_count;
  logic        check, unlock, fail, alarm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign equal = (pressed_code == 16'h1234);

  lock_keypad_entry #(.MAX_TRIES(3), .OPEN_CYCLES(16), .LOCKOUT_CYCLES(64)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_cancel(key_cancel), .equal(equal),
    .pressed_code(pressed_code), .digit_count(digit_count),
    .check(check), .unlock(unlock), .fail(fail), .alarm(alarm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; key_valid = 1'b0; key_enter = 1'b0; key_cancel = 1'b0;
    tick(); tick();
    clr = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic entry(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic enter_key();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic cancel_key();
    key_cancel = 1'b1;
    tick();
    key_cancel = 1'b0;
  endtask

  // Enters 1,2,3,5 and reports fail/alarm one cycle after the check cycle.
  task automatic wrong_try(output logic f, output logic a);
    entry(4'h1, 4'h2, 4'h3, 4'h5);
    enter_key();
    tick();
    f = fail; a = alarm;
    if (f) tick();
  endtask

  // Counts cycles with unlock high, starting at the edge after the call.
  task automatic count_unlock(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (unlock) n++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    checks++;
    if ({pressed_code, digit_count, check, unlock, fail, alarm} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {pressed_code, digit_count, check, unlock, fail, alarm});
    end
    clr = 1'b0;
  endtask

  task automatic test_unlock();
    int n;
    do_reset();
    entry(4'h1, 4'h2, 4'h3, 4'h4);
    checks++;
    if (pressed_code !== 16'h1234 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL unlock_code: got %h/%0d, expected 1234/4", pressed_code, digit_count);
    end
    enter_key();
    checks++;
    if (check !== 1'b1 || unlock !== 1'b0) begin
      errors++;
      $display("FAIL unlock_check_cycle: check=%b unlock=%b, expected 1/0", check, unlock);
    end
    tick();
    checks++;
    if (check !== 1'b0 || unlock !== 1'b1) begin
      errors++;
      $display("FAIL unlock_start: check=%b unlock=%b, expected 0/1", check, unlock);
    end
    count_unlock(30, n);
    checks++;
    if (n + 1 != 16) begin
      errors++;
      $display("FAIL unlock_len: got %0d cycles, expected 16", n + 1);
    end
    checks++;
    if (pressed_code !== 16'h0000 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL unlock_exit_clear: got %h/%0d, expected 0000/0", pressed_code, digit_count);
    end
  endtask

  task automatic test_five_digits();
    int n;
    do_reset();
    key(4'h9);
    entry(4'h1, 4'h2, 4'h3, 4'h4);
    checks++;
    if (pressed_code !== 16'h1234 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL five_digits: got %h/%0d, expected 1234/4", pressed_code, digit_count);
    end
    enter_key();
    count_unlock(20, n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL five_digits_unlock: got %0d cycles, expected 16", n);
    end
  endtask

  task automatic test_lockout();
    logic f, a;
    int n, bad, fails_seen, u;
    do_reset();
    for (int t = 1; t <= 2; t++) begin
      wrong_try(f, a);
      checks++;
      if (f !== 1'b1 || a !== 1'b0) begin
        errors++;
        $display("FAIL lockout_try%0d: fail=%b alarm=%b, expected 1/0", t, f, a);
      end
    end
    wrong_try(f, a);
    checks++;
    if (f !== 1'b0 || a !== 1'b1) begin
      errors++;
      $display("FAIL lockout_try3: fail=%b alarm=%b, expected 0/1", f, a);
    end
    n = 1; bad = 0; fails_seen = 0;
    for (int i = 0; i < 80; i++) begin
      key_valid = alarm;
      key_digit = 4'(i);
      key_enter = alarm & (i % 3 == 0);
      tick();
      if (alarm) n++;
      if (alarm && pressed_code !== 16'h1235) bad++;
      if (fail || check) fails_seen++;
    end
    key_valid = 1'b0; key_enter = 1'b0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL lockout_len: got %0d cycles, expected 64", n);
    end
    checks++;
    if (bad != 0 || fails_seen != 0) begin
      errors++;
      $display("FAIL lockout_keys_ignored: %0d code changes, %0d fail/check, expected 0/0",
               bad, fails_seen);
    end
    entry(4'h1, 4'h2, 4'h3, 4'h4);
    enter_key();
    count_unlock(20, u);
    checks++;
    if (u != 16) begin
      errors++;
      $display("FAIL lockout_then_unlock: got %0d cycles, expected 16", u);
    end
  endtask

  task automatic test_cancel_and_tries();
    logic f, a;
    int u;
    do_reset();
    wrong_try(f, a);
    wrong_try(f, a);
    key(4'h1); key(4'h2);
    cancel_key();
    checks++;
    if (pressed_code !== 16'h0000 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL cancel_clear: got %h/%0d, expected 0000/0", pressed_code, digit_count);
    end
    entry(4'h1, 4'h2, 4'h3, 4'h4);
    enter_key();
    count_unlock(20, u);
    checks++;
    if (u != 16) begin
      errors++;
      $display("FAIL cancel_not_attempt: unlock %0d cycles, expected 16", u);
    end
    wrong_try(f, a);
    checks++;
    if (f !== 1'b1 || a !== 1'b0) begin
      errors++;
      $display("FAIL tries_reset_1: fail=%b alarm=%b, expected 1/0", f, a);
    end
    wrong_try(f, a);
    checks++;
    if (f !== 1'b1 || a !== 1'b0) begin
      errors++;
      $display("FAIL tries_reset_2: fail=%b alarm=%b, expected 1/0", f, a);
    end
  endtask

  task automatic test_short_and_priority();
    do_reset();
    key(4'h1); key(4'h2); key(4'h3);
    enter_key();
    checks++;
    if (check !== 1'b0 || fail !== 1'b1) begin
      errors++;
      $display("FAIL short_entry: check=%b fail=%b, expected 0/1", check, fail);
    end
    tick();
    checks++;
    if (pressed_code !== 16'h0000 || digit_count !== 3'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL short_exit: got %h/%0d fail=%b, expected 0000/0/0",
               pressed_code, digit_count, fail);
    end
    key(4'h1); key(4'h2);
    key_valid = 1'b1; key_digit = 4'h5; key_enter = 1'b1; key_cancel = 1'b1;
    tick();
    key_valid = 1'b0; key_enter = 1'b0; key_cancel = 1'b0;
    checks++;
    if (pressed_code !== 16'h0000 || digit_count !== 3'd0 || check !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL cancel_priority: got %h/%0d check=%b fail=%b, expected 0000/0/0/0",
               pressed_code, digit_count, check, fail);
    end
    key_valid = 1'b1; key_digit = 4'h7; key_cancel = 1'b1;
    tick();
    key_valid = 1'b0; key_cancel = 1'b0;
    checks++;
    if (pressed_code !== 16'h0000 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL idle_cancel_priority: got %h/%0d, expected 0000/0", pressed_code, digit_count);
    end
  endtask

  task automatic test_clr_mid();
    logic f, a;
    do_reset();
    entry(4'h1, 4'h2, 4'h3, 4'h4);
    enter_key();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (unlock !== 1'b1) begin
      errors++;
      $display("FAIL clr_open_pre: unlock=%b, expected 1", unlock);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (unlock !== 1'b0 || pressed_code !== 16'h0000 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL clr_open: unlock=%b code=%h count=%0d, expected 0/0000/0",
               unlock, pressed_code, digit_count);
    end
    wrong_try(f, a);
    wrong_try(f, a);
    wrong_try(f, a);
    for (int i = 0; i < 10; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (alarm !== 1'b0 || pressed_code !== 16'h0000 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL clr_lockout: alarm=%b code=%h count=%0d, expected 0/0000/0",
               alarm, pressed_code, digit_count);
    end
    wrong_try(f, a);
    wrong_try(f, a);
    checks++;
    if (f !== 1'b1 || a !== 1'b0) begin
      errors++;
      $display("FAIL clr_tries_cleared: fail=%b alarm=%b, expected 1/0", f, a);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_five_digits();
    test_lockout();
    test_cancel_and_tries();
    test_short_and_priority();
    test_clr_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
